// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage of the 5-stage MIPS pipeline.
// Holds the PC and a word-addressed instruction memory that the debug loader
// fills through a write port. Each edge it selects the next PC (sequential,
// branch, jump or jump-register) and drives the IF/ID register. It also
// handles load-use stalls, flushes on redirect, a debug step gate and a HALT
// instruction that stops fetching until the next redirect.
module instruction_fetch_stage #(
    parameter int              LEN            = 32,
    parameter int              NB_ADDRESS_MEM = 10,
    parameter int              NB_PC_SRC      = 2,
    parameter int              NB_JUMP_INDEX  = 26,
    parameter logic [LEN-1:0]  HALT_WORD      = 32'hFFFF_FFFF,
    parameter logic [LEN-1:0]  NOP_WORD       = 32'h0000_0000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    input  logic                      i_stall,
    input  logic [NB_PC_SRC-1:0]      i_pc_src,
    input  logic [LEN-1:0]            i_branch_target,
    input  logic [NB_JUMP_INDEX-1:0]  i_jump_index,
    input  logic [LEN-1:0]            i_jr_target,
    input  logic                      i_mem_wr_en,
    input  logic [NB_ADDRESS_MEM-1:0] i_mem_wr_addr,
    input  logic [LEN-1:0]            i_mem_wr_data,
    output logic [LEN-1:0]            o_instruccion,
    output logic [LEN-1:0]            o_adder_pc,
    output logic [LEN-1:0]            o_pc,
    output logic                      o_valid,
    output logic                      o_halt
);

    localparam int DEPTH      = 2 ** NB_ADDRESS_MEM;
    // PC bits kept above the jump index: PC+4[31:28] for the 32-bit datapath.
    localparam int NB_PC_HIGH = LEN - NB_JUMP_INDEX - 2;

    localparam logic [NB_PC_SRC-1:0] SRC_SEQ    = NB_PC_SRC'(0);
    localparam logic [NB_PC_SRC-1:0] SRC_BRANCH = NB_PC_SRC'(1);
    localparam logic [NB_PC_SRC-1:0] SRC_JUMP   = NB_PC_SRC'(2);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    logic [LEN-1:0] mem [DEPTH];

    state_t         state_reg;
    logic [LEN-1:0] pc_reg;
    logic [LEN-1:0] instr_reg;
    logic [LEN-1:0] adder_pc_reg;
    logic           valid_reg;
    logic           halt_reg;

    logic [LEN-1:0] pc_plus4;
    logic [LEN-1:0] fetch_word;
    logic [LEN-1:0] jump_target;
    logic [LEN-1:0] redirect_target;
    logic           redirect;

    // PC arithmetic wraps modulo 2**LEN; low two PC bits and bits above the
    // memory depth do not take part in addressing, so the memory aliases.
    assign pc_plus4    = pc_reg + LEN'(4);
    assign fetch_word  = mem[pc_reg[NB_ADDRESS_MEM+1:2]];
    assign jump_target = {pc_plus4[LEN-1 -: NB_PC_HIGH], i_jump_index, 2'b00};
    assign redirect    = (i_pc_src != SRC_SEQ);

    // Select the redirect target for branch, jump and jump-register.
    always_comb begin
        redirect_target = i_jr_target;
        case (i_pc_src)
            SRC_BRANCH: redirect_target = i_branch_target;
            SRC_JUMP:   redirect_target = jump_target;
            default:    redirect_target = i_jr_target;
        endcase
    end

    // Debug loader write port; runs regardless of enable, stall or halt.
    // The fetch read is combinational from the pre-edge contents, so a write
    // to the address being fetched is seen only from the next cycle.
    always_ff @(posedge i_clk) begin
        if (i_mem_wr_en) begin
            mem[i_mem_wr_addr] <= i_mem_wr_data;
        end
    end

    // PC, IF/ID register and RUN/HALTED control in priority order:
    // debug gate, redirect, halted, stall, normal fetch.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg    <= ST_RUN;
            pc_reg       <= '0;
            instr_reg    <= NOP_WORD;
            adder_pc_reg <= '0;
            valid_reg    <= 1'b0;
            halt_reg     <= 1'b0;
        end else if (!i_enable) begin
            // Frozen between debug steps.
        end else if (redirect) begin
            // A redirect means the instructions behind it (including any HALT)
            // were on the wrong path: flush IF/ID and resume running.
            pc_reg       <= redirect_target;
            instr_reg    <= NOP_WORD;
            adder_pc_reg <= '0;
            valid_reg    <= 1'b0;
            state_reg    <= ST_RUN;
            halt_reg     <= 1'b0;
        end else if (state_reg == ST_HALTED) begin
            instr_reg    <= NOP_WORD;
            valid_reg    <= 1'b0;
            halt_reg     <= 1'b1;
        end else if (i_stall) begin
            // Load-use stall: PC and IF/ID hold.
        end else begin
            instr_reg    <= fetch_word;
            adder_pc_reg <= pc_plus4;
            valid_reg    <= 1'b1;
            if (fetch_word == HALT_WORD) begin
                state_reg <= ST_HALTED;
                halt_reg  <= 1'b1;
            end else begin
                pc_reg    <= pc_plus4;
            end
        end
    end

    assign o_instruccion = instr_reg;
    assign o_adder_pc    = adder_pc_reg;
    assign o_pc          = pc_reg;
    assign o_valid       = valid_reg;
    assign o_halt        = halt_reg;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Testbench for instruction_fetch_stage: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the fetch rules.
module tb_instruction_fetch_stage;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] instr;
    logic [31:0] adder_pc;
    logic [31:0] pc;
    logic        valid;
    logic        halt;

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_adder;
    logic        m_valid;
    logic        m_halt;

    always #5 clk = ~clk;

    instruction_fetch_stage dut (
        .i_clk           (clk),
        .i_rst           (rst_n),
        .i_enable        (enable),
        .i_stall         (stall),
        .i_pc_src        (pc_src),
        .i_branch_target (branch_target),
        .i_jump_index    (jump_index),
        .i_jr_target     (jr_target),
        .i_mem_wr_en     (wr_en),
        .i_mem_wr_addr   (wr_addr),
        .i_mem_wr_data   (wr_data),
        .o_instruccion   (instr),
        .o_adder_pc      (adder_pc),
        .o_pc            (pc),
        .o_valid         (valid),
        .o_halt          (halt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},    pc,       m_pc);
        chk({tag, ".instr"}, instr,    m_instr);
        chk({tag, ".adder"}, adder_pc, m_adder);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, m_valid});
        chk({tag, ".halt"},  {31'd0, halt},  {31'd0, m_halt});
    endtask

    task automatic model_reset();
        m_pc    = 32'd0;
        m_instr = 32'd0;
        m_adder = 32'd0;
        m_valid = 1'b0;
        m_halt  = 1'b0;
    endtask

    // One clock edge of the fetch rules, evaluated on the inputs present at the edge.
    task automatic model_edge();
        logic [31:0] w;
        if (enable) begin
            if (pc_src != 2'd0) begin
                case (pc_src)
                    2'd1:    m_pc = branch_target;
                    2'd2:    m_pc = ((m_pc + 32'd4) & 32'hF000_0000) + ({6'd0, jump_index} * 32'd4);
                    default: m_pc = jr_target;
                endcase
                m_instr = 32'd0;
                m_adder = 32'd0;
                m_valid = 1'b0;
                m_halt  = 1'b0;
            end else if (m_halt) begin
                m_instr = 32'd0;
                m_valid = 1'b0;
            end else if (!stall) begin
                w       = m_mem[int'((m_pc / 32'd4) % DEPTH)];
                m_instr = w;
                m_adder = m_pc + 32'd4;
                m_valid = 1'b1;
                if (w == HALT) m_halt = 1'b1;
                else           m_pc   = m_pc + 32'd4;
            end
        end
        if (wr_en) m_mem[wr_addr] = wr_data;
    endtask

    task automatic idle_inputs();
        enable        = 1'b1;
        stall         = 1'b0;
        pc_src        = 2'd0;
        branch_target = 32'd0;
        jump_index    = 26'd0;
        jr_target     = 32'd0;
        wr_en         = 1'b0;
        wr_addr       = 10'd0;
        wr_data       = 32'd0;
    endtask

    // One transaction: apply the current inputs on the next edge, then check.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
        $display("%-8s en=%0b st=%0b src=%0d pc=%08h instr=%08h adder=%08h valid=%0b halt=%0b",
                 tag, enable, stall, pc_src, pc, instr, adder_pc, valid, halt);
        idle_inputs();
    endtask

    task automatic redirect_to(input logic [31:0] target, input string tag);
        pc_src        = 2'd1;
        branch_target = target;
        step(tag);
    endtask

    logic [31:0] exp_i [4];
    logic [31:0] exp_a [4];
    logic [31:0] w;
    logic [31:0] old_word;
    logic [31:0] save_instr;
    logic [31:0] save_pc;

    initial begin
        exp_i[0] = 32'h2001_0005; exp_i[1] = 32'h2002_0007;
        exp_i[2] = 32'h0022_1820; exp_i[3] = HALT;
        exp_a[0] = 32'd4; exp_a[1] = 32'd8; exp_a[2] = 32'd12; exp_a[3] = 32'd16;

        idle_inputs();
        enable = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        #12;
        chk_all("reset");
        rst_n = 1'b1;

        // Load program (debug loader) with fetch frozen.
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            if (w == HALT) w = 32'h1234_5678;
            if (i < 4) w = exp_i[i];
            enable  = 1'b0;
            wr_en   = 1'b1;
            wr_addr = 10'(i);
            wr_data = w;
            @(posedge clk);
            model_edge();
            #1;
        end
        idle_inputs();
        enable = 1'b0;
        step("loaded");

        // Straight-line program ending in HALT.
        for (int i = 0; i < 4; i++) begin
            step("prog");
            chk("prog.instr_k", instr, exp_i[i]);
            chk("prog.adder_k", adder_pc, exp_a[i]);
        end
        chk("prog.halt_k", {31'd0, halt}, 32'd1);
        chk("prog.pc_k", pc, 32'd12);
        step("halted");
        chk("halted.valid_k", {31'd0, valid}, 32'd0);
        chk("halted.pc_k", pc, 32'd12);

        // Leave halt by redirect, then stall at PC=8.
        redirect_to(32'd8, "unhalt");
        chk("unhalt.halt_k", {31'd0, halt}, 32'd0);
        chk("unhalt.pc_k", pc, 32'd8);
        redirect_to(32'd4, "redir4");
        step("fetch4");
        chk("fetch4.pc_k", pc, 32'd8);
        stall = 1'b1; step("stall1");
        stall = 1'b1; step("stall2");
        chk("stall.pc_k", pc, 32'd8);
        chk("stall.instr_k", instr, 32'h2002_0007);
        step("resume");
        chk("resume.instr_k", instr, 32'h0022_1820);

        // Redirect beats stall.
        redirect_to(32'd8, "redir8");
        pc_src = 2'd1; branch_target = 32'h40; stall = 1'b1;
        step("br_stall");
        chk("br_stall.pc_k", pc, 32'h40);
        chk("br_stall.instr_k", instr, 32'd0);

        // Jump and jump-register.
        pc_src = 2'd3; jr_target = 32'h1000_0010; step("jr_hi");
        pc_src = 2'd2; jump_index = 26'h0000040; step("jump");
        chk("jump.pc_k", pc, 32'h1000_0100);
        pc_src = 2'd3; jr_target = 32'h24; step("jr");
        chk("jr.pc_k", pc, 32'h24);
        step("fetch24");

        // Debug gate closed for 3 cycles while a write lands.
        save_pc    = pc;
        save_instr = instr;
        enable = 1'b0; wr_en = 1'b1; wr_addr = 10'd20; wr_data = 32'hABCD_0001;
        step("frz1");
        enable = 1'b0; step("frz2");
        enable = 1'b0; step("frz3");
        chk("frz.pc_k", pc, save_pc);
        chk("frz.instr_k", instr, save_instr);
        redirect_to(32'd80, "redir80");
        step("fetch80");
        chk("fetch80.instr_k", instr, 32'hABCD_0001);

        // Same-address write while fetching: old word captured.
        redirect_to(32'h30, "redir30");
        old_word = m_mem[12];
        wr_en = 1'b1; wr_addr = 10'd12; wr_data = 32'h5A5A_5A5A;
        step("rbw");
        chk("rbw.instr_k", instr, old_word);
        redirect_to(32'h30, "redir30b");
        step("newword");
        chk("newword.instr_k", instr, 32'h5A5A_5A5A);

        // Async reset mid-cycle while halted.
        redirect_to(32'hC, "redirC");
        step("haltC");
        chk("haltC.halt_k", {31'd0, halt}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        #1;
        rst_n = 1'b1;
        step("post_rst");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            enable = ($urandom_range(0, 9) != 0);
            stall  = ($urandom_range(0, 4) == 0);
            pc_src = ($urandom_range(0, 9) < 2) ? 2'($urandom_range(1, 3)) : 2'd0;
            branch_target = ($urandom_range(0, 3) == 0) ? $urandom : {20'd0, 10'($urandom), 2'b00};
            jump_index    = 26'($urandom);
            jr_target     = ($urandom_range(0, 3) == 0) ? $urandom : {22'd0, 8'($urandom), 2'b00};
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 10'($urandom);
            wr_data = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
